// File: rtl/time_set_ctrl_if.sv
// Keypad/DIP-switch inputs and time-counter/display outputs of the time-setting sequencer.
interface time_set_ctrl_if;
   logic        set_mode;
   logic [9:0]  keypad;
   logic [23:0] cur_time;
   logic        hold;
   logic        load;
   logic [23:0] load_time;
   logic        disp_sel;
   logic [23:0] disp_time;
   logic [2:0]  cursor;
   logic        err;
   logic [5:0]  digit_blank;

   modport master (
      output set_mode, keypad, cur_time,
      input  hold, load, load_time, disp_sel, disp_time, cursor, err, digit_blank
   );

   modport slave (
      input  set_mode, keypad, cur_time,
      output hold, load, load_time, disp_sel, disp_time, cursor, err, digit_blank
   );
endinterface

// File: rtl/time_set_ctrl.sv
// Watch time-setting sequencer: keypad debounce, 24-hour BCD validation, edit buffer, commit strobe.
// Define BLINK_EN to blink the digit under the cursor; otherwise digit_blank is tied to 0.
module time_set_ctrl #(
   parameter int DEBOUNCE    = 20,
   parameter int TIMEOUT_CYC = 5000
`ifdef BLINK_EN
   , parameter int BLINK_CYC = 250
`endif
) (
   input  logic            i_clk,
   input  logic            i_rst_n,
   time_set_ctrl_if.slave  bus
);
   localparam int DEB_W = $clog2(DEBOUNCE + 1);
   localparam int TO_W  = $clog2(TIMEOUT_CYC);

   typedef enum logic [1:0] {S_IDLE, S_ENTRY, S_COMMIT, S_DONE} state_t;

   state_t             r_state, w_state_next;
   logic               r_set_prev, r_set_rise;
   logic [9:0]         r_key_prev;
   logic [DEB_W-1:0]   r_press_cnt, r_rel_cnt, w_press_next;
   logic               r_released, r_key_evt;
   logic [3:0]         r_key_digit, w_key_idx, w_limit;
   logic               w_onehot, w_digit_ok;
   logic [23:0]        r_buf, w_buf_next, r_load_time, w_load_time_next;
   logic [2:0]         r_cursor, w_cursor_next;
   logic [TO_W-1:0]    r_timeout, w_timeout_next;
   logic               r_hold, r_load, r_disp_sel, r_err, w_err_next;

   // ---------------- key decoder ----------------
   assign w_onehot = (bus.keypad != 10'd0) && ((bus.keypad & (bus.keypad - 10'd1)) == 10'd0);

   always_comb begin
      w_key_idx = 4'd0;
      for (int k = 0; k < 10; k++)
         if (bus.keypad[k]) w_key_idx = 4'(k);
   end

   assign w_press_next = (bus.keypad == r_key_prev) ? r_press_cnt + DEB_W'(1) : DEB_W'(1);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_key_prev  <= '0;
         r_press_cnt <= '0;
         r_rel_cnt   <= '0;
         r_released  <= 1'b1;
         r_key_evt   <= 1'b0;
         r_key_digit <= '0;
      end else begin
         r_key_prev <= bus.keypad;
         r_key_evt  <= 1'b0;
         if (bus.keypad == 10'd0) begin
            r_press_cnt <= '0;
            if (r_rel_cnt < DEB_W'(DEBOUNCE)) begin
               r_rel_cnt <= r_rel_cnt + DEB_W'(1);
               if (r_rel_cnt == DEB_W'(DEBOUNCE - 1)) r_released <= 1'b1;
            end
         end else begin
            r_rel_cnt <= '0;
            // Only a clean one-hot code after a qualified release can count toward a press.
            if (w_onehot && r_released) begin
               if (w_press_next == DEB_W'(DEBOUNCE)) begin
                  r_key_evt   <= 1'b1;
                  r_key_digit <= w_key_idx;
                  r_released  <= 1'b0;
                  r_press_cnt <= '0;
               end else begin
                  r_press_cnt <= w_press_next;
               end
            end else begin
               r_press_cnt <= '0;
            end
         end
      end
   end

   // ---------------- digit validation ----------------
   always_comb begin
      case (r_cursor)
         3'd0:    w_limit = 4'd2;
         3'd1:    w_limit = (r_buf[23:20] == 4'd2) ? 4'd3 : 4'd9;
         3'd2:    w_limit = 4'd5;
         3'd4:    w_limit = 4'd5;
         default: w_limit = 4'd9;
      endcase
   end

   assign w_digit_ok = (r_key_digit <= w_limit);

   // ---------------- sequencer ----------------
   always_comb begin
      w_state_next     = r_state;
      w_buf_next       = r_buf;
      w_cursor_next    = r_cursor;
      w_timeout_next   = '0;
      w_err_next       = 1'b0;
      w_load_time_next = r_load_time;
      case (r_state)
         S_IDLE: begin
            if (r_set_rise) begin
               w_state_next  = S_ENTRY;
               w_buf_next    = bus.cur_time;
               w_cursor_next = 3'd0;
            end
         end
         S_ENTRY: begin
            w_timeout_next = r_timeout + TO_W'(1);
            if (!bus.set_mode) begin
               w_state_next = S_IDLE;
            end else if (r_key_evt && w_digit_ok) begin
               for (int p = 0; p < 6; p++)
                  if (r_cursor == 3'(p)) w_buf_next[20-4*p +: 4] = r_key_digit;
               // Hours 2x: clamp a preloaded h_one above 3 so the buffer stays legal.
               if (r_cursor == 3'd0 && r_key_digit == 4'd2 && r_buf[19:16] > 4'd3)
                  w_buf_next[19:16] = 4'd3;
               w_timeout_next = '0;
               if (r_cursor == 3'd5) begin
                  w_state_next     = S_COMMIT;
                  w_load_time_next = w_buf_next;
               end else begin
                  w_cursor_next = r_cursor + 3'd1;
               end
            end else begin
               if (r_key_evt) w_err_next = 1'b1;
               if (r_timeout == TO_W'(TIMEOUT_CYC - 1)) begin
                  w_err_next   = 1'b1;
                  w_state_next = S_DONE;
               end
            end
         end
         S_COMMIT: w_state_next = S_DONE;
         S_DONE: begin
            if (!bus.set_mode) w_state_next = S_IDLE;
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Previous set_mode resets high so a switch already on at reset release is not an edge.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_set_prev  <= 1'b1;
         r_set_rise  <= 1'b0;
         r_buf       <= '0;
         r_cursor    <= '0;
         r_timeout   <= '0;
         r_hold      <= 1'b0;
         r_load      <= 1'b0;
         r_load_time <= '0;
         r_disp_sel  <= 1'b0;
         r_err       <= 1'b0;
      end else begin
         r_set_prev  <= bus.set_mode;
         r_set_rise  <= bus.set_mode & ~r_set_prev;
         r_buf       <= w_buf_next;
         r_cursor    <= w_cursor_next;
         r_timeout   <= w_timeout_next;
         r_hold      <= (w_state_next == S_ENTRY) || (w_state_next == S_COMMIT);
         r_disp_sel  <= (w_state_next == S_ENTRY) || (w_state_next == S_COMMIT);
         r_load      <= (w_state_next == S_COMMIT);
         r_load_time <= w_load_time_next;
         r_err       <= w_err_next;
      end
   end

`ifdef BLINK_EN
   localparam int BL_W = (BLINK_CYC > 1) ? $clog2(BLINK_CYC) : 1;

   logic [BL_W-1:0] r_blink_cnt, w_blink_cnt_next;
   logic            r_blink_phase, w_blink_phase_next;
   logic [5:0]      r_digit_blank, w_digit_blank_next;

   always_comb begin
      w_blink_cnt_next   = '0;
      w_blink_phase_next = 1'b0;
      w_digit_blank_next = '0;
      if (w_state_next == S_ENTRY) begin
         // Phase restarts unblanked on entry and on every cursor move.
         if (r_state != S_ENTRY || w_cursor_next != r_cursor) begin
            w_blink_cnt_next   = '0;
            w_blink_phase_next = 1'b0;
         end else if (r_blink_cnt == BL_W'(BLINK_CYC - 1)) begin
            w_blink_cnt_next   = '0;
            w_blink_phase_next = ~r_blink_phase;
         end else begin
            w_blink_cnt_next   = r_blink_cnt + BL_W'(1);
            w_blink_phase_next = r_blink_phase;
         end
         for (int p = 0; p < 6; p++)
            if (w_cursor_next == 3'(p)) w_digit_blank_next[5-p] = w_blink_phase_next;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_blink_cnt   <= '0;
         r_blink_phase <= 1'b0;
         r_digit_blank <= '0;
      end else begin
         r_blink_cnt   <= w_blink_cnt_next;
         r_blink_phase <= w_blink_phase_next;
         r_digit_blank <= w_digit_blank_next;
      end
   end

   assign bus.digit_blank = r_digit_blank;
`else
   assign bus.digit_blank = 6'd0;
`endif

   assign bus.hold      = r_hold;
   assign bus.load      = r_load;
   assign bus.load_time = r_load_time;
   assign bus.disp_sel  = r_disp_sel;
   assign bus.disp_time = r_buf;
   assign bus.cursor    = r_cursor;
   assign bus.err       = r_err;
endmodule

// File: tb/tb_time_set_ctrl.sv
// Self-checking bench for time_set_ctrl: load values are scoreboarded, other results checked inline.
module tb_time_set_ctrl;
   localparam int DEB = 20;
   localparam int TO  = 5000;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   time_set_ctrl_if bus();

   time_set_ctrl #(.DEBOUNCE(DEB), .TIMEOUT_CYC(TO)) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bus)
   );

   int          n_vec  = 0;
   int          n_miss = 0;
   int          n_load = 0;
   int          n_err  = 0;
   bit          after_load = 1'b0;
   logic [23:0] exp_q[$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end else begin
         $display("ok   %s: %0h", tag, got);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic press(input int d);
      bus.keypad = 10'(1 << d);
      cyc(DEB + 2);
      bus.keypad = '0;
      cyc(DEB + 2);
   endtask

   task automatic check_reset(input string pfx);
      check({pfx, "_hold"},        32'(bus.hold),        0);
      check({pfx, "_load"},        32'(bus.load),        0);
      check({pfx, "_load_time"},   32'(bus.load_time),   0);
      check({pfx, "_disp_sel"},    32'(bus.disp_sel),    0);
      check({pfx, "_disp_time"},   32'(bus.disp_time),   0);
      check({pfx, "_cursor"},      32'(bus.cursor),      0);
      check({pfx, "_err"},         32'(bus.err),         0);
      check({pfx, "_digit_blank"}, 32'(bus.digit_blank), 0);
   endtask

   // Output monitor: pops the scoreboard on every load strobe.
   always @(negedge clk) begin
      if (rst_n) begin
         if (after_load) begin
            check("hold_drop_after_load", 32'(bus.hold), 0);
            after_load = 1'b0;
         end
         if (bus.load) begin
            n_load++;
            check("hold_during_load", 32'(bus.hold), 1);
            check("sb_nonempty", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) check("load_time", 32'(bus.load_time), 32'(exp_q.pop_front()));
            after_load = 1'b1;
         end
         if (bus.err) n_err++;
      end
   end

   initial begin
      int e0;
      int lat;
      bus.set_mode = 1'b1;
      bus.keypad   = '0;
      bus.cur_time = 24'h081500;

      // Reset, released while set_mode is already high: no edit may start.
      #2 rst_n = 1'b0;
      cyc(3);
      check_reset("rst");
      rst_n = 1'b1;
      cyc(5);
      check("no_edge_at_rst_release", 32'(bus.hold), 0);
      bus.set_mode = 1'b0;
      cyc(3);

      // Full entry 1..6 and commit.
      bus.set_mode = 1'b1;
      cyc(1);
      check("edge_lat_cyc1_hold", 32'(bus.hold), 0);
      cyc(1);
      check("edge_lat_cyc2_hold", 32'(bus.hold), 1);
      check("entry_disp_sel", 32'(bus.disp_sel), 1);
      check("entry_preload", 32'(bus.disp_time), 32'h081500);
      check("entry_cursor", 32'(bus.cursor), 0);
      bus.keypad = 10'(1 << 1);
      cyc(DEB);
      check("deb_lat_early_cursor", 32'(bus.cursor), 0);
      cyc(1);
      check("deb_lat_cursor", 32'(bus.cursor), 1);
      cyc(1);
      bus.keypad = '0;
      cyc(DEB + 2);
      for (int d = 2; d <= 5; d++) press(d);
      check("pre_commit_hold", 32'(bus.hold), 1);
      exp_q.push_back(24'h123456);
      press(6);
      check("commit_load_count", 32'(n_load), 1);
      check("done_hold", 32'(bus.hold), 0);
      check("done_disp_sel", 32'(bus.disp_sel), 0);
      bus.set_mode = 1'b0;
      cyc(3);

      // Limits, clamp of h_one and rejected digits.
      bus.cur_time = 24'h090000;
      bus.set_mode = 1'b1;
      cyc(3);
      e0 = n_err;
      press(2);
      check("clamp_h_one", 32'(bus.disp_time[23:16]), 32'h23);
      check("cursor_after_2", 32'(bus.cursor), 1);
      press(7);
      check("err_pos1_7", 32'(n_err - e0), 1);
      check("cursor_after_reject", 32'(bus.cursor), 1);
      press(3);
      check("cursor_after_3", 32'(bus.cursor), 2);
      check("buf_hours", 32'(bus.disp_time[23:16]), 32'h23);
      press(6);
      check("err_pos2_6", 32'(n_err - e0), 2);
      check("cursor_after_reject2", 32'(bus.cursor), 2);
      press(5);
      check("cursor_after_5", 32'(bus.cursor), 3);
      check("buf_after_5", 32'(bus.disp_time), 32'h235000);

      // Glitch then multi-hot: nothing accepted.
      bus.keypad = 10'h010;
      cyc(10);
      bus.keypad = 10'h003;
      cyc(40);
      bus.keypad = '0;
      cyc(DEB + 2);
      check("glitch_cursor", 32'(bus.cursor), 3);
      check("glitch_no_err", 32'(n_err - e0), 2);

      // Abort by dropping set_mode.
      bus.set_mode = 1'b0;
      cyc(1);
      check("abort_disp_sel", 32'(bus.disp_sel), 0);
      check("abort_hold", 32'(bus.hold), 0);
      cyc(2);
      check("abort_no_load", 32'(n_load), 1);

      // Idle timeout.
      bus.cur_time = 24'h111111;
      bus.set_mode = 1'b1;
      e0 = n_err;
      lat = 0;
      for (int i = 1; i <= TO + 100; i++) begin
         @(negedge clk);
         if (bus.err) begin
            lat = i;
            break;
         end
      end
      check("timeout_latency", 32'(lat), 32'(TO + 2));
      cyc(2);
      check("timeout_err_once", 32'(n_err - e0), 1);
      check("timeout_hold", 32'(bus.hold), 0);
      check("timeout_disp_sel", 32'(bus.disp_sel), 0);
      press(4);
      check("done_key_ignored_buf", 32'(bus.disp_time), 32'h111111);
      check("done_key_ignored_cursor", 32'(bus.cursor), 0);
      check("done_key_no_err", 32'(n_err - e0), 1);
      bus.set_mode = 1'b0;
      cyc(2);
      bus.set_mode = 1'b1;
      cyc(3);
      check("reentry_hold", 32'(bus.hold), 1);

      // Reset mid-entry at cursor 4.
      for (int d = 1; d <= 4; d++) press(d);
      check("mid_cursor", 32'(bus.cursor), 4);
      #2 rst_n = 1'b0;
      #1;
      check_reset("rst_mid");
      cyc(3);
      rst_n = 1'b1;
      cyc(4);
      check("post_rst_no_entry", 32'(bus.hold), 0);
      bus.set_mode = 1'b0;
      bus.cur_time = 24'h203040;
      cyc(2);
      bus.set_mode = 1'b1;
      cyc(3);
      check("restart_hold", 32'(bus.hold), 1);
      check("restart_cursor", 32'(bus.cursor), 0);
      check("restart_preload", 32'(bus.disp_time), 32'h203040);
      bus.set_mode = 1'b0;
      cyc(3);
      check("total_loads", 32'(n_load), 1);
      check("sb_empty", 32'(exp_q.size()), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end
endmodule

// File: doc/time_set_ctrl.md
# time_set_ctrl

Sequencer that owns the watch's time-setting path. It debounces and decodes the one-hot keypad, validates each BCD digit against 24-hour limits, and holds the six-digit entry in a buffer. It then commits the buffer to the time counter with a single-cycle load strobe. It sits between the keypad/DIP switch and the time counter/display mux, and freezes the counter while an edit is in progress.

## Interface
- DEBOUNCE, 20: consecutive stable cycles required for a key press and for a key release.
- TIMEOUT_CYC, 5000: idle cycles in ENTRY before the edit is abandoned (5 s at 1 kHz).
- BLINK_CYC, 250: half-period of the cursor blink, in cycles (used only with BLINK_EN).
- clk  in  1  1 kHz system clock.
- rst  in  1  asynchronous, active-low reset.
- set_mode  in  1  DIP switch level; 1 = setting requested.
- keypad  in  10  one-hot key lines; bit k = digit k.
- cur_time  in  24  live BCD time: [23:20] h_ten, [19:16] h_one, … [3:0] s_one.
- hold  out  1  1 = the time counter must not advance.
- load  out  1  one-cycle commit strobe.
- load_time  out  24  BCD value to load; valid while load = 1, same packing as cur_time.
- disp_sel  out  1  1 = display shows disp_time; 0 = display shows cur_time.
- disp_time  out  24  edit buffer.
- cursor  out  3  next digit position, 0 (h_ten) … 5 (s_one).
- err  out  1  one-cycle pulse on a rejected digit or a timeout.
- digit_blank  out  6  per-digit blanking; bit 5 = h_ten.

## Operation
- States: IDLE, ENTRY, COMMIT, DONE.
- IDLE
  - On a set_mode 0→1 edge (registered previous value), go to ENTRY.
  - On entry to ENTRY: buffer ← cur_time, cursor ← 0, timeout counter ← 0.
  - If set_mode is already 1 when reset is released, do not enter ENTRY; an edge is required.
- Key decoder
  - A press is accepted when keypad holds the same exactly-one-hot code for DEBOUNCE consecutive cycles after a qualified release.
  - A qualified release is keypad = 0 for DEBOUNCE consecutive cycles; reset counts as released.
  - A multi-hot or changing code restarts the press count and is never accepted.
  - Each accepted press produces exactly one digit event.
  - The decoder runs in all states; events outside ENTRY are discarded.
- ENTRY, on a digit event d at position cursor
  - Limits: pos0 ≤2; pos1 ≤9, or ≤3 if buffer h_ten = 2; pos2 ≤5; pos3 ≤9; pos4 ≤5; pos5 ≤9.
  - Valid digit: write d into the buffer nibble, cursor + 1, clear the timeout counter.
  - Invalid digit: pulse err; buffer and cursor unchanged.
  - Valid digit at pos5: go to COMMIT.
  - A valid pos0 = 2 with a buffered h_one > 3: also force h_one to 3, so the buffer stays a legal time.
- Exits from ENTRY
  - set_mode = 0: go to IDLE, no load.
  - Timeout counter reaches TIMEOUT_CYC − 1 with no valid digit: pulse err, go to DONE, no load.
  - set_mode low and timeout in the same cycle: set_mode wins; go to IDLE, no err.
- COMMIT: load = 1 with load_time = buffer for exactly one cycle, then DONE.
- DONE: stay until set_mode = 0, then IDLE. A new edit requires another 0→1 edge.
- Output decode
  - hold = 1 in ENTRY and COMMIT.
  - disp_sel = 1 in ENTRY and COMMIT.
  - disp_time = buffer.

## Timing
- Reset values: state IDLE; hold 0, load 0, load_time 0, disp_sel 0, disp_time 0, cursor 0, err 0, digit_blank 0; all debounce, timeout and blink counters 0.
- All outputs are registered.
- set_mode edge → hold/disp_sel = 1: two cycles (one cycle for the edge register, one for the state).
- First cycle of a stable key code → buffer and cursor updated: DEBOUNCE + 1 cycles.
- Sixth valid digit accepted → load high on the next cycle; hold drops on the cycle after load.
- A reset assertion at any point returns every output to its reset value immediately. A partial entry is lost and no load is issued.

## Configuration
- BLINK_EN defined
  - In ENTRY, digit_blank bit (5 − cursor) toggles every BLINK_CYC cycles, starting unblanked.
  - The blink phase restarts on every cursor change.
  - All other bits of digit_blank are 0.
- BLINK_EN undefined: digit_blank is constant 0 and there is no blink counter.

## Test plan
- Key in 1,2,3,4,5,6 with releases: load pulses once, with load_time = 0x123456; hold is 1 from ENTRY through COMMIT.
- Key in 2 then 7: err pulses, cursor stays 1; then key 3 → cursor 2, buffer [23:16] = 0x23.
- 10-cycle glitch on keypad bit 4, then 2'b11 on bits 1:0 held for 40 cycles: no digit accepted, cursor unchanged.
- Three digits entered, then set_mode drops: IDLE, no load, disp_sel = 0 after 1 cycle, counter resumes.
- No key for 5000 cycles in ENTRY: err pulses once, state DONE, no load; raising keys has no effect until set_mode toggles.
- Reset pulsed low mid-entry at cursor = 4: all outputs return to their reset values; the following set_mode edge restarts entry at cursor 0 preloaded from cur_time.
